// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   mem_size_e   : request access size encoding (matches req_size)
//   lsu_state_e  : controller state, also exported on the debug port
//   LANE_BYTES   : byte lanes per RAM word
//   is_misaligned: alignment/legality check for a request
package lsu_pkg;

  localparam int WORD_BITS  = 32;
  localparam int LANE_BYTES = WORD_BITS / 8;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } mem_size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } lsu_state_e;

  // A request faults when its size is illegal or its address is not a
  // multiple of the access size.
  function automatic logic is_misaligned(mem_size_e size, logic [1:0] offset);
    logic bad;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = offset[0];
      WORD:    bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the load/store unit.
//   word        : RAM word as read back
//   offset      : byte offset of the access within the word
//   size        : access size
//   is_unsigned : zero-extend loads instead of sign-extend
//   store_data  : low half of the store data (only bytes/halves are merged)
//   load_data   : selected lane, extended to a full word
//   merge_data  : word with the store lane replaced, other bytes preserved
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [WORD_BITS-1:0] word,
  input  logic [1:0]           offset,
  input  mem_size_e            size,
  input  logic                 is_unsigned,
  input  logic [15:0]          store_data,
  output logic [WORD_BITS-1:0] load_data,
  output logic [WORD_BITS-1:0] merge_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    // Little-endian: byte k lives in bits 8k+7:8k.
    byte_lane = word[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (size)
      BYTE: load_data = is_unsigned ? {24'h0, byte_lane}
                                    : {{24{byte_lane[7]}}, byte_lane};
      HALF: load_data = is_unsigned ? {16'h0, half_lane}
                                    : {{16{half_lane[15]}}, half_lane};
      default: load_data = word;
    endcase

    merge_data = word;
    case (size)
      BYTE: merge_data[{offset, 3'b000} +: 8] = store_data[7:0];
      HALF: begin
        if (offset[1]) merge_data[31:16] = store_data;
        else           merge_data[15:0]  = store_data;
      end
      default: merge_data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core datapath and a word-addressed RAM with
// one-cycle registered read latency and no byte enables. Sub-word stores are
// done as read-modify-write.
// Ports:
//   clk, rst (async, active-low)
//   req_*  : request channel. A request transfers on a rising edge where
//            req_valid && req_ready; the requester holds it stable until
//            then. req_ready is high only while idle, so one request is in
//            flight at a time.
//   rsp_*  : rsp_valid is a one-cycle completion pulse; rsp_rdata and
//            rsp_misaligned are valid with it and hold until the next one.
//   mem_*  : RAM port; mem_read_data is valid the cycle after mem_addr.
//   debug_state : current controller state.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_SIZE-1:0] rsp_rdata,
  output logic                 rsp_misaligned,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_write_enable,
  output logic [DATA_SIZE-1:0] mem_write_data,
  input  logic [DATA_SIZE-1:0] mem_read_data,
  output lsu_state_e           debug_state
);

  lsu_state_e state_q, state_d;

  // Latched request fields.
  logic       write_q;
  mem_size_e  size_q;
  logic       unsigned_q;
  logic [1:0] offset_q;
  logic [15:0] wdata_q;

  logic [ADDR_SIZE-1:0] mem_addr_q;
  logic [DATA_SIZE-1:0] mem_wdata_q;
  logic [DATA_SIZE-1:0] rsp_rdata_q;
  logic                 rsp_mis_q;

  mem_size_e req_size_e;
  logic      accept;
  logic      req_bad;

  logic [DATA_SIZE-1:0] load_data;
  logic [DATA_SIZE-1:0] merge_data;

  assign req_size_e = mem_size_e'(req_size);
  assign accept     = (state_q == IDLE) && req_valid;
  assign req_bad    = is_misaligned(req_size_e, req_addr[1:0]);

  lsu_lane_align u_lane_align (
    .word        (mem_read_data),
    .offset      (offset_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bad)                            state_d = RESP;
          else if (req_write && req_size_e == WORD) state_d = WRITE;
          else                                    state_d = READ;
        end
      end
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = write_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= BYTE;
      unsigned_q  <= 1'b0;
      offset_q    <= 2'b00;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q    <= req_write;
        size_q     <= req_size_e;
        unsigned_q <= req_unsigned;
        offset_q   <= req_addr[1:0];
        wdata_q    <= req_wdata[15:0];
        mem_addr_q <= {req_addr[ADDR_SIZE-1:2], 2'b00};
        if (req_bad) begin
          rsp_rdata_q <= '0;
          rsp_mis_q   <= 1'b1;
        end else if (req_write && req_size_e == WORD) begin
          mem_wdata_q <= req_wdata;
        end
      end
      // Response registers only change on the way into RESP, so they hold
      // their value between responses.
      if (state_q == CAPTURE) begin
        if (write_q) begin
          mem_wdata_q <= merge_data;
        end else begin
          rsp_rdata_q <= load_data;
          rsp_mis_q   <= 1'b0;
        end
      end
      if (state_q == WRITE) begin
        rsp_rdata_q <= '0;
        rsp_mis_q   <= 1'b0;
      end
    end
  end

  // Decoded straight from the state register so that an async reset drops
  // the write strobe immediately.
  assign mem_write_enable = (state_q == WRITE);
  assign req_ready        = (state_q == IDLE);
  assign rsp_valid        = (state_q == RESP);
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_misaligned   = rsp_mis_q;
  assign mem_addr         = mem_addr_q;
  assign mem_write_data   = mem_wdata_q;
  assign debug_state      = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic [31:0] mem_addr;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  lsu_state_e  debug_state;

  load_store_unit #(.ADDR_SIZE(32), .DATA_SIZE(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_misaligned   (rsp_misaligned),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .debug_state      (debug_state)
  );

  // ---------------- RAM model: registered read, read-old ----------------
  logic [31:0] ram [256];
  initial for (int i = 0; i < 256; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_write_enable) ram[mem_addr[9:2]] <= mem_write_data;
    mem_read_data <= ram[mem_addr[9:2]];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  // ---------------- driver ----------------
  // Issues one request from a negedge, returns latency (cycles after the
  // acceptance edge until rsp_valid), response fields and write-strobe count.
  task automatic do_req(input logic write, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata,
                        output logic mis, output int we_cnt, output logic [31:0] maddr);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid    = 1'b1;
    req_write    = write;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat    = 1;
    we_cnt = 0;
    while (!rsp_valid && lat < 20) begin
      if (mem_write_enable) we_cnt++;
      @(negedge clk);
      lat++;
    end
    if (mem_write_enable) we_cnt++;
    rdata = rsp_rdata;
    mis   = rsp_misaligned;
    maddr = mem_addr;
  endtask

  int          lat, we_cnt, guard;
  logic [31:0] rdata, maddr, saved_word;
  logic        mis;

  initial begin
    vecs[0]  = '{"sw_100",   1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0,        0, 2, 1};
    vecs[1]  = '{"lw_100",   0, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 3, 0};
    vecs[2]  = '{"sw_104",   1, 2'b10, 0, 32'h104, 32'h11223344, 32'h0,        0, 2, 1};
    vecs[3]  = '{"sb_105",   1, 2'b00, 0, 32'h105, 32'h00000080, 32'h0,        0, 4, 1};
    vecs[4]  = '{"lw_104a",  0, 2'b10, 0, 32'h104, 32'h0,        32'h11228044, 0, 3, 0};
    vecs[5]  = '{"lb_105",   0, 2'b00, 0, 32'h105, 32'h0,        32'hFFFFFF80, 0, 3, 0};
    vecs[6]  = '{"lbu_105",  0, 2'b00, 1, 32'h105, 32'h0,        32'h00000080, 0, 3, 0};
    vecs[7]  = '{"sh_106",   1, 2'b01, 0, 32'h106, 32'hCAFEBEEF, 32'h0,        0, 4, 1};
    vecs[8]  = '{"lw_104b",  0, 2'b10, 0, 32'h104, 32'h0,        32'hBEEF8044, 0, 3, 0};
    vecs[9]  = '{"lh_106",   0, 2'b01, 0, 32'h106, 32'h0,        32'hFFFFBEEF, 0, 3, 0};
    vecs[10] = '{"lhu_106",  0, 2'b01, 1, 32'h106, 32'h0,        32'h0000BEEF, 0, 3, 0};
    vecs[11] = '{"lw_102",   0, 2'b10, 0, 32'h102, 32'h0,        32'h0,        1, 1, 0};
    vecs[12] = '{"sh_101",   1, 2'b01, 0, 32'h101, 32'h00001234, 32'h0,        1, 1, 0};
    vecs[13] = '{"lw_104c",  0, 2'b10, 0, 32'h104, 32'h0,        32'hBEEF8044, 0, 3, 0};
    vecs[14] = '{"ill_108",  0, 2'b11, 0, 32'h108, 32'h0,        32'h0,        1, 1, 0};
    vecs[15] = '{"lb_107",   0, 2'b00, 0, 32'h107, 32'h0,        32'hFFFFFFBE, 0, 3, 0};
    vecs[16] = '{"lbu_104",  0, 2'b00, 1, 32'h104, 32'h0,        32'h00000044, 0, 3, 0};
    vecs[17] = '{"sb_107",   1, 2'b00, 1, 32'h107, 32'hAAAAAA7F, 32'h0,        0, 4, 1};
    vecs[18] = '{"lw_104d",  0, 2'b10, 0, 32'h104, 32'h0,        32'h7FEF8044, 0, 3, 0};
    vecs[19] = '{"lh_104",   0, 2'b01, 0, 32'h104, 32'h0,        32'hFFFF8044, 0, 3, 0};

    // ---- reset state ----
    #12;
    check("rst_ready",  {31'h0, req_ready}, 32'h1);
    check("rst_valid",  {31'h0, rsp_valid}, 32'h0);
    check("rst_rdata",  rsp_rdata, 32'h0);
    check("rst_mis",    {31'h0, rsp_misaligned}, 32'h0);
    check("rst_maddr",  mem_addr, 32'h0);
    check("rst_we",     {31'h0, mem_write_enable}, 32'h0);
    check("rst_wdata",  mem_write_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i].write, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
             lat, rdata, mis, we_cnt, maddr);
      check({vecs[i].name, "_lat"},   lat, vecs[i].exp_lat);
      check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
      check({vecs[i].name, "_mis"},   {31'h0, mis}, {31'h0, vecs[i].exp_mis});
      check({vecs[i].name, "_we"},    we_cnt, vecs[i].exp_we);
      check({vecs[i].name, "_maddr"}, maddr, vecs[i].addr & 32'hFFFF_FFFC);
      @(negedge clk);
      check({vecs[i].name, "_ready_after"}, {31'h0, req_ready}, 32'h1);
      check({vecs[i].name, "_valid_drop"},  {31'h0, rsp_valid}, 32'h0);
    end
    exp_q.push_back(32'h7FEF8044);

    // ---- reset while idle ----
    #2 rst = 1'b0;
    #1;
    check("idle_rst_ready", {31'h0, req_ready}, 32'h1);
    check("idle_rst_rdata", rsp_rdata, 32'h0);
    check("idle_rst_maddr", mem_addr, 32'h0);
    check("idle_rst_wdata", mem_write_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // ---- reset during WRITE of a byte store ----
    saved_word = ram[32'h104 >> 2];
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h104; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    guard = 1;
    while (!mem_write_enable && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("wrst_reach_write", guard, 3);
    #2 rst = 1'b0;
    #1;
    check("wrst_we_drop", {31'h0, mem_write_enable}, 32'h0);
    check("wrst_state",   {29'h0, debug_state}, {29'h0, IDLE});
    @(posedge clk);
    @(negedge clk);
    check("wrst_no_rsp",  {31'h0, rsp_valid}, 32'h0);
    check("wrst_ram",     ram[32'h104 >> 2], saved_word);
    rst = 1'b1;
    @(negedge clk);
    check("wrst_ready",   {31'h0, req_ready}, 32'h1);
    do_req(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, lat, rdata, mis, we_cnt, maddr);
    check("wrst_lw_lat",   lat, 3);
    check("wrst_lw_rdata", rdata, exp_q.pop_front());

    // ---- report ----
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core datapath and the word-addressed data RAM. Accepts one load or store request at a time over a valid/ready handshake and checks its alignment. Drives the RAM's plain addr/write_enable/write_data/read_data port, with one-cycle registered read latency and no byte enables. Sub-word stores are performed as read-modify-write; loads return sign- or zero-extended data with a one-cycle response pulse.

## Interface
- ADDR_SIZE, 32, byte address width
- DATA_SIZE, 32, word width; only 32 supported (4 byte lanes)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend loads (ignored for word and stores)
- req_addr  in  ADDR_SIZE  byte address
- req_wdata  in  DATA_SIZE  store data, LSB-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_SIZE  extended load data (0 for stores/faults)
- rsp_misaligned  out  1  request faulted, qualified by rsp_valid
- mem_addr  out  ADDR_SIZE  word-aligned address, low 2 bits always 0
- mem_write_enable  out  1  RAM write strobe
- mem_write_data  out  DATA_SIZE  full word to write
- mem_read_data  in  DATA_SIZE  RAM data, valid the cycle after mem_addr is presented

## Operation
- States: IDLE, READ, CAPTURE, WRITE, RESP.
- req_ready = (state == IDLE). A request is accepted on a rising edge with req_valid & req_ready; all request fields are latched.
- Misaligned check: half with addr[0]=1, word with addr[1:0]≠0, or size 11. The transition is IDLE→RESP with rsp_misaligned=1 and rsp_rdata=0. No RAM access occurs.
- Load: IDLE→READ→CAPTURE→RESP.
  - CAPTURE selects the lane from mem_read_data (byte k = bits 8k+7:8k, little-endian, k = addr[1:0]; half = addr[1]).
  - The lane is extended and registered into rsp_rdata.
- Store word: IDLE→WRITE→RESP. mem_write_data = req_wdata.
- Store byte/half: IDLE→READ→CAPTURE→WRITE→RESP.
  - CAPTURE merges req_wdata[7:0] or req_wdata[15:0] into the lane of mem_read_data and registers the result as mem_write_data. Other bytes are preserved.
- mem_write_enable = 1 only in WRITE. mem_addr holds the latched aligned address from acceptance until the next acceptance.
- RESP lasts exactly one cycle, then returns to IDLE. rsp_rdata and rsp_misaligned hold until the next RESP.
- Reset:
  - Async assertion forces IDLE immediately.
  - mem_write_enable drops combinationally, including mid-WRITE.
  - Any in-flight request is discarded with no response.
- Reset values: req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_misaligned 0, mem_addr 0, mem_write_enable 0, mem_write_data 0.

## Timing
- Request accepted at edge N (cycle N = acceptance cycle):
  - Misaligned: rsp_valid in cycle N+1.
  - Store word: WRITE in N+1, rsp_valid in N+2.
  - Load: READ in N+1, CAPTURE in N+2, rsp_valid in N+3.
  - Sub-word store: READ in N+1, CAPTURE in N+2, WRITE in N+3, rsp_valid in N+4.
- req_ready is low from N+1 through the RESP cycle. It is high again the cycle after RESP.
- Back-to-back: minimum spacing between acceptances is latency+1. No overlap of requests.
- A request held with req_valid while busy is not lost; the requester must keep it stable until accepted.

## Structure
- Package lsu_pkg holds:
  - mem_size_e (BYTE, HALF, WORD, ILLEGAL)
  - lsu_state_e
  - LANE_BYTES = DATA_SIZE/8
- Sub-module lsu_lane_align (combinational) performs the lane work:
  - Extract plus sign/zero-extend for loads.
  - Merge for sub-word stores.
  - Inputs: word, offset, size, unsigned, store data.
- The top level holds the FSM, request latch and output registers.

## Test plan
- Reset: hold rst=0 mid-idle → all outputs at reset values, req_ready=1. Release → unit accepts on the next edge.
- SW 0xDEADBEEF at 0x100, then LW 0x100:
  - Store: rsp_valid at N+2, mem_write_enable high exactly one cycle, mem_addr=0x100.
  - Load: rsp_valid at N+3, rsp_rdata=0xDEADBEEF.
- RAM word 0x104=0x11223344; SB 0x80 at 0x105:
  - RAM becomes 0x11228044, write at N+3.
  - LB 0x105 → 0xFFFFFF80.
  - LBU 0x105 → 0x00000080.
- SH 0xBEEF at 0x106 over 0x11228044:
  - RAM becomes 0xBEEF8044.
  - LH 0x106 → 0xFFFFBEEF.
  - LHU 0x106 → 0x0000BEEF.
- LW 0x102, and SH at 0x101:
  - rsp_valid at N+1 with rsp_misaligned=1, rsp_rdata=0.
  - mem_write_enable never asserted, RAM unchanged.
- Assert rst during WRITE of SB to 0x104:
  - mem_write_enable falls in the same cycle, no rsp_valid, RAM word unchanged.
  - After release, req_ready=1 and a following LW returns the original word.
